// File: rtl/rx_word_deser.sv
// rx_word_deser: bipolar RZ bit deserializer with hold-until-ack word output.
// Optional odd-parity check on committed words under RX_PARITY_CHK_EN.
module rx_word_deser #(
  parameter int NBIT = 32,
  parameter int CW   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            res,
  input  logic            RXP,
  input  logic            RXN,
  input  logic            ack,
  output logic [NBIT-1:0] data,
  output logic            word_rdy,
  output logic            err_len,
  output logic            err_code,
  output logic            ovr,
  output logic            par_err
);
  typedef enum logic [1:0] {SYNC, IDLE, RECV, DISC} state_t;
  state_t          r_st, w_nx;
  logic            r_tp, r_tn;
  logic [NBIT-1:0] r_sr;
  logic [CW-1:0]   r_cnt;
  logic            w_pb, w_nb, w_code, w_gap, w_pulse, w_full;
  logic            w_shift, w_commit, w_lerr;
  assign w_pb    = RXP & ~r_tp;
  assign w_nb    = RXN & ~r_tn;
  assign w_code  = RXP & RXN;
  assign w_gap   = ce & res;
  // a gap outranks any edge in the same sample; a both-lines sample is never a bit
  assign w_pulse = ce & ~res & ~w_code & (w_pb ^ w_nb);
  assign w_full  = r_cnt == CW'(NBIT);
  always_comb begin
    w_nx     = r_st;
    w_shift  = 1'b0;
    w_commit = 1'b0;
    w_lerr   = 1'b0;
    case (r_st)
      SYNC: w_nx = w_gap ? IDLE : SYNC;
      IDLE: begin
        w_nx    = w_pulse ? RECV : IDLE;
        w_shift = w_pulse;
      end
      RECV: begin
        w_nx     = w_gap ? IDLE : (w_pulse & w_full) ? DISC : RECV;
        w_commit = w_gap & w_full;
        w_lerr   = w_gap & ~w_full;
        w_shift  = ~w_gap & w_pulse & ~w_full;
      end
      DISC: begin
        w_nx   = w_gap ? IDLE : DISC;
        w_lerr = w_gap;
      end
      default: w_nx = SYNC;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st     <= SYNC;
      r_tp     <= 1'b0;
      r_tn     <= 1'b0;
      r_sr     <= '0;
      r_cnt    <= '0;
      data     <= '0;
      word_rdy <= 1'b0;
      err_len  <= 1'b0;
      err_code <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      r_st <= w_nx;
      if (ce) begin
        r_tp <= RXP;
        r_tn <= RXN;
      end
      if (w_shift) r_sr <= {w_pb, r_sr[NBIT-1:1]};
      r_cnt    <= w_shift ? r_cnt + CW'(1) : (w_nx == IDLE ? '0 : r_cnt);
      err_code <= ce & w_code;
      err_len  <= w_lerr;
      // commit outranks a coincident ack, and an acked overwrite is not an overrun
      word_rdy <= w_commit | (word_rdy & ~ack);
      ovr      <= ~ack & (ovr | (w_commit & word_rdy));
      if (w_commit) data <= r_sr;
    end
  end
`ifdef RX_PARITY_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) par_err <= 1'b0;
    else if (w_commit) par_err <= ~(^r_sr);
  end
`else
  assign par_err = 1'b0;
`endif
endmodule

// File: doc/rx_word_deser.md
Name: rx_word_deser

Overview:
- Bit-level deserializer directly downstream of the bipolar RZ receive timer.
- Consumes the timer's sample strobe `ce` and word-gap strobe `res`, together with the raw RXP/RXN line pair.
- Decodes each RZ pulse into one bit and assembles NBIT-bit words.
- Presents each completed word with a hold-until-acknowledge handshake, plus length, code, overrun and (optional) parity error flags.

Parameters:
- NBIT, 32, bits per word; legal range 8..32.
- CW, 6, width of the bit counter; must satisfy 2^CW > NBIT.

Ports:
- clk, input, 1, system clock (50 MHz).
- rst, input, 1, synchronous active-high reset.
- ce, input, 1, one-clk sample strobe from the receive timer (Tbit/NP period).
- res, input, 1, word-gap indication from the timer; may stay high for several clk; only acted on when ce=1.
- RXP, input, 1, positive line; pulse = logic 1.
- RXN, input, 1, negative line; pulse = logic 0.
- ack, input, 1, consumer acknowledges the held word; acted on every clk.
- data, output, NBIT, last accepted word; first received bit lands in data[0].
- word_rdy, output, 1, high while an unacknowledged word is held.
- err_len, output, 1, 1-clk pulse: word closed with bit count != NBIT.
- err_code, output, 1, 1-clk pulse: RXP and RXN both high at a ce sample.
- ovr, output, 1, sticky: a word completed while word_rdy=1; cleared by rst or ack.
- par_err, output, 1, parity status of the word held on data (see Optional Feature).

Behaviour:
- Reset (rst=1 at clk edge): data=0, word_rdy=0, err_len=0, err_code=0, ovr=0, par_err=0, shift reg=0, bit count=0, tRXP=tRXN=0, state=SYNC. Reset mid-word discards the partial word.
- Edge detect, evaluated only when ce=1:
  - tRXP<=RXP, tRXN<=RXN.
  - pbit = RXP&!tRXP, nbit = RXN&!tRXN.
  - err_code pulses if RXP&RXN at that ce; such a sample is not shifted.
- States:
  - SYNC: ignore pulses; on ce&res -> IDLE. Guarantees alignment to a gap after reset.
  - IDLE: count=0; on ce & (pbit|nbit) -> RECV, shift the bit in, count=1.
  - RECV: on ce & (pbit^nbit): sr<={pbit,sr[NBIT-1:1]}, count<=count+1.
    - If count would exceed NBIT -> DISCARD (no shift beyond NBIT; counter saturates).
    - On ce&res with count==NBIT -> commit, -> IDLE.
    - On ce&res with count!=NBIT -> err_len pulse, no commit, -> IDLE.
  - DISCARD: ignore pulses; on ce&res -> err_len pulse, -> IDLE.
- Commit, registered on the clk edge that samples ce&res:
  - data<=sr, word_rdy<=1, par_err updated.
  - If word_rdy was already 1 and ack=0 in that cycle: data is still overwritten and ovr<=1.
- Handshake:
  - ack=1 clears word_rdy and ovr the next clk.
  - If commit and ack coincide, commit wins: word_rdy stays 1 and ovr is not set.
- Latency: word_rdy rises 1 clk after the ce cycle in which res is seen.
- pbit and nbit in the same ce: err_code, treated as no pulse.
- ce&res and a pulse edge in the same ce: res takes priority; the pulse is ignored.

Optional Feature:
- Macro: RX_PARITY_CHK_EN.
- Defined: at commit, par_err<=~(^sr); odd parity over all NBIT bits is required. par_err is held with data until the next commit or rst.
- Undefined: par_err is constant 0, and no parity logic is synthesized.

Test Plan:
- rst, then a ce&res gap, then 32 pulses (RXP for even bit indices, RXN for odd), then ce&res -> data=32'h55555555 one clk after the res-ce, word_rdy=1, err_len=0.
- Same as above with only 31 pulses before ce&res -> err_len single-clk pulse, word_rdy stays 0, data unchanged.
- 33 pulses, then ce&res -> DISCARD path, err_len pulse, no commit.
- Two valid words, no ack between them -> second word on data, ovr=1; ack -> word_rdy=0 and ovr=0 on the next clk.
- RXP&RXN high at one ce mid-word -> err_code pulse; that bit is not counted, so the word closes with 31 bits and err_len fires.
- RX_PARITY_CHK_EN defined: word 32'h00000001 -> par_err=0; word 32'h00000003 -> par_err=1. Without the macro, par_err=0 for both.
